instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 32 +++
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_decode.sv | 34 +++
 rtl/instr_fetch.sv | 120 ++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch unit and its decoder.
// Instruction words are numbered MSB-first: bit [0] is the MSB.
package instr_fetch_pkg;

    // Instruction classes presented on o_kind
    localparam logic [0:1] KIND_DT  = 2'b00;
    localparam logic [0:1] KIND_MV  = 2'b01;
    localparam logic [0:1] KIND_OP  = 2'b10;
    localparam logic [0:1] KIND_ILL = 2'b11;

    // Opcode prefixes
    localparam logic [0:1] PFX_DT = 2'b00;
    localparam logic [0:2] PFX_MV = 3'b110;
    localparam logic [0:2] PFX_OP = 3'b111;

    // Field bit positions within the 18-bit instruction
    localparam int unsigned IMM_HI = 2;
    localparam int unsigned IMM_LO = 17;
    localparam int unsigned DST_HI = 3;
    localparam int unsigned DST_LO = 5;
    localparam int unsigned SRC_HI = 6;
    localparam int unsigned SRC_LO = 8;
    localparam int unsigned OP_HI  = 3;
    localparam int unsigned OP_LO  = 8;

    // Fetch unit states
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Handshake bundle between the fetch unit and the execute stage.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic        valid;
    logic        ready;
    logic [0:1]  kind;
    logic [0:15] imm;
    logic [0:2]  dst;
    logic [0:2]  src;
    logic [0:5]  op;
    logic [0:15] pc;
    logic        jump_valid;
    logic [0:15] jump_addr;

    // Fetch side: presents decoded instructions, receives redirects
    modport master (
        output valid, kind, imm, dst, src, op, pc,
        input  ready, jump_valid, jump_addr
    );

    // Execute side: consumes decoded instructions, issues redirects
    modport slave (
        input  valid, kind, imm, dst, src, op, pc,
        output ready, jump_valid, jump_addr
    );

endinterface

// File: rtl/instr_decode.sv
// Combinational instruction decoder: classifies the word and extracts
// its fields; fields not belonging to the decoded class read as zero.
module instr_decode
    import instr_fetch_pkg::*;
(
    input  logic [0:17] i_instr,
    output logic [0:1]  o_kind,
    output logic [0:15] o_imm,
    output logic [0:2]  o_dst,
    output logic [0:2]  o_src,
    output logic [0:5]  o_op
);

    // Prefix match and field extraction
    always_comb begin
        o_kind = KIND_ILL;
        o_imm  = '0;
        o_dst  = '0;
        o_src  = '0;
        o_op   = '0;
        if (i_instr[0:1] == PFX_DT) begin
            o_kind = KIND_DT;
            o_imm  = i_instr[IMM_HI:IMM_LO];
        end else if (i_instr[0:2] == PFX_MV) begin
            o_kind = KIND_MV;
            o_dst  = i_instr[DST_HI:DST_LO];
            o_src  = i_instr[SRC_HI:SRC_LO];
        end else if (i_instr[0:2] == PFX_OP) begin
            o_kind = KIND_OP;
            o_op   = i_instr[OP_HI:OP_LO];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the ROM address from the PC, decodes the
// returned word into a one-entry output buffer with valid/ready handshake,
// halts on an illegal instruction and accepts redirects from execute.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [0:15] RESET_PC = 16'd0,
    parameter logic [0:15] PROG_LEN = 16'd7
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [0:15] o_addr,
    input  logic [0:17] i_instr,
    input  logic        i_jump_valid,
    input  logic [0:15] i_jump_addr,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [0:1]  o_kind,
    output logic [0:15] o_imm,
    output logic [0:2]  o_dst,
    output logic [0:2]  o_src,
    output logic [0:5]  o_op,
    output logic [0:15] o_pc,
    output logic        o_halted
);

    state_t      state_q, state_d;
    logic [0:15] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [0:1]  kind_q, kind_d;
    logic [0:15] imm_q, imm_d;
    logic [0:2]  dst_q, dst_d;
    logic [0:2]  src_q, src_d;
    logic [0:5]  op_q, op_d;
    logic [0:15] opc_q, opc_d;

    logic [0:1]  dec_kind;
    logic [0:15] dec_imm;
    logic [0:2]  dec_dst;
    logic [0:2]  dec_src;
    logic [0:5]  dec_op;

    instr_decode u_decode (
        .i_instr (i_instr),
        .o_kind  (dec_kind),
        .o_imm   (dec_imm),
        .o_dst   (dec_dst),
        .o_src   (dec_src),
        .o_op    (dec_op)
    );

    // Next-state: redirect beats everything, then load when the buffer frees up
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        kind_d  = kind_q;
        imm_d   = imm_q;
        dst_d   = dst_q;
        src_d   = src_q;
        op_d    = op_q;
        opc_d   = opc_q;
        if (i_jump_valid) begin
            // Target taken as-is; the buffered instruction is dropped
            state_d = ST_FETCH;
            pc_d    = i_jump_addr;
            valid_d = 1'b0;
        end else if (state_q == ST_FETCH && (!valid_q || i_ready)) begin
            if (dec_kind == KIND_ILL) begin
                state_d = ST_HALT;
                valid_d = 1'b0;
            end else begin
                valid_d = 1'b1;
                kind_d  = dec_kind;
                imm_d   = dec_imm;
                dst_d   = dec_dst;
                src_d   = dec_src;
                op_d    = dec_op;
                opc_d   = pc_q;
                pc_d    = (pc_q == PROG_LEN - 16'd1) ? '0 : pc_q + 16'd1;
            end
        end
    end

    // State, PC and output buffer registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            kind_q  <= KIND_DT;
            imm_q   <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            op_q    <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            kind_q  <= kind_d;
            imm_q   <= imm_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            op_q    <= op_d;
            opc_q   <= opc_d;
        end
    end

    assign o_addr   = pc_q;
    assign o_valid  = valid_q;
    assign o_kind   = kind_q;
    assign o_imm    = imm_q;
    assign o_dst    = dst_q;
    assign o_src    = src_q;
    assign o_op     = op_q;
    assign o_pc     = opc_q;
    assign o_halted = (state_q == ST_HALT);

endmodule
